alu_muldiv_unit: RTL and testbench



---
 rtl/alu_muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit (shift-add multiply, restoring divide).
// Latency: XLEN cycles from accept to out_valid for normal ops, 1 cycle for divide special cases.
// Backpressure: in_ready only in IDLE; result and out_valid are held in DONE until out_ready, kill or reset.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; funct3/op_a/op_b are sampled only on the accept edge
//   kill                synchronous abort, returns to IDLE and drops any pending result
//   out_valid/out_ready result handshake; result is registered
module alu_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int              CW      = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            neg;      // final result must be negated
  logic            special;  // result already known, finish on the first CALC edge
  logic [XLEN-1:0] mcand;    // multiplicand for MUL*, divisor for DIV*/REM*
  logic [XLEN-1:0] hi;       // upper product half / partial remainder
  logic [XLEN-1:0] lo;       // multiplier shifting out / dividend shifting out, quotient shifting in

  // ---------------- request decode ----------------
  logic            sgn_a, sgn_b, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, is_special, neg_in;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    sgn_a    = !(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
    sgn_b    = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    sa       = sgn_a & op_a[XLEN-1];
    sb       = sgn_b & op_b[XLEN-1];
    a_mag    = sa ? -op_a : op_a;
    b_mag    = sb ? -op_b : op_b;
    div_zero = funct3[2] && (op_b == '0);
    // Only the signed DIV/REM encodings (funct3[0] = 0) can overflow.
    div_ovf  = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    is_special = div_zero | div_ovf;
    // funct3[1] selects remainder among the divide ops.
    if (div_zero) spec_res = funct3[1] ? op_a : '1;
    else          spec_res = funct3[1] ? '0 : op_a;
    // Remainder takes the dividend's sign; product and quotient take sa^sb.
    neg_in = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
  end

  // ---------------- one iteration ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   nxt_hi, nxt_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand};
    if (op[2]) begin
      // Borrow out of the XLEN+1-bit subtract means restore.
      nxt_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      nxt_lo = {lo[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], lo[XLEN-1:1]};
    end

    prod     = {nxt_hi, nxt_lo};
    prod_fix = neg ? -prod : prod;
    quo_fix  = neg ? -nxt_lo : nxt_lo;
    rem_fix  = neg ? -nxt_hi : nxt_hi;

    fin_res = rem_fix;
    case (op)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo_fix;
      default:                fin_res = rem_fix;
    endcase
  end

  assign in_ready = (state == IDLE);

  // ---------------- control and datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      neg       <= 1'b0;
      special   <= 1'b0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (kill) begin
      // Also blocks an accept while IDLE.
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op      <= funct3;
            neg     <= neg_in;
            cnt     <= '0;
            hi      <= '0;
            special <= is_special;
            state   <= CALC;
            if (is_special) begin
              // Parked in lo so the result only appears together with out_valid.
              mcand <= '0;
              lo    <= spec_res;
            end else begin
              mcand <= funct3[2] ? b_mag : a_mag;
              lo    <= funct3[2] ? a_mag : b_mag;
            end
          end
        end
        CALC: begin
          if (special) begin
            result    <= lo;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            hi  <= nxt_hi;
            lo  <= nxt_lo;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              cnt       <= '0;
              result    <= fin_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, kill, out_valid, out_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a, op_b, result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  // Reference: plain 64-bit arithmetic following the RISC-V M rules.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'h0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issues one request from IDLE, scrambles the inputs after the accept edge,
  // waits (bounded) for out_valid, then completes the output handshake.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic rdy_after);
    @(negedge clk);
    in_valid = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rdy_after = in_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", result); end
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[14];
    logic [31:0] res;
    int lat;
    logic rdy;
    v[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32};
    v[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32};
    v[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
    v[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32};
    v[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32};
    v[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32};
    v[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        32};
    v[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         32};
    v[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    v[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    v[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    v[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
    v[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    v[13] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1};
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, res, lat, rdy);
      tests++; if (res !== v[i].exp) begin fails++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, v[i].exp); end
      tests++; if (lat !== v[i].lat) begin fails++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat); end
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL directed_in_ready_after[%0d]: got %b expected 1", i, rdy); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res;
    logic [2:0] f;
    int lat;
    logic rdy;
    for (int i = 0; i < 250; i++) begin
      f = 3'($urandom);
      a = pick();
      b = pick();
      run_op(f, a, b, res, lat, rdy);
      tests++; if (res !== ref_op(f, a, b)) begin fails++; $display("FAIL random_result f=%0d a=%h b=%h: got %h expected %h", f, a, b, res, ref_op(f, a, b)); end
      tests++; if (lat !== ref_lat(f, a, b)) begin fails++; $display("FAIL random_latency f=%0d a=%h b=%h: got %0d expected %0d", f, a, b, lat, ref_lat(f, a, b)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp;
    int lat;
    a = $urandom; b = $urandom;
    exp = ref_op(3'd1, a, b);
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd1; op_a = a; op_b = b;
    @(negedge clk);
    lat = 0;
    // Keep in_valid asserted with a different request: it must be ignored.
    funct3 = 3'd0; op_a = $urandom; op_b = $urandom;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== XLEN) begin fails++; $display("FAIL bp_latency: got %0d expected %0d", lat, XLEN); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      tests++; if (result !== exp) begin fails++; $display("FAIL bp_result[%0d]: got %h expected %h", i, result, exp); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_no_pending_accept: got %b expected 1", in_ready); end
  endtask

  task automatic test_kill();
    logic [31:0] a, b, res;
    int lat;
    logic rdy;
    bit seen;
    // Kill at iteration 10.
    a = $urandom; b = $urandom_range(1, 1000);
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd5; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL kill_calc_in_ready: got %b expected 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL kill_calc_out_valid: got %b expected 0", out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL kill_never_valid: got %b expected 0", seen); end
    a = pick(); b = pick();
    run_op(3'd6, a, b, res, lat, rdy);
    tests++; if (res !== ref_op(3'd6, a, b)) begin fails++; $display("FAIL kill_next_result: got %h expected %h", res, ref_op(3'd6, a, b)); end
    tests++; if (lat !== ref_lat(3'd6, a, b)) begin fails++; $display("FAIL kill_next_latency: got %0d expected %0d", lat, ref_lat(3'd6, a, b)); end

    // Kill while holding a result in DONE.
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd0; op_a = $urandom; op_b = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    tests++; if (lat !== XLEN) begin fails++; $display("FAIL kill_done_latency: got %0d expected %0d", lat, XLEN); end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL kill_done_out_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL kill_done_in_ready: got %b expected 1", in_ready); end

    // Kill in IDLE blocks the accept.
    @(negedge clk);
    in_valid = 1'b1; kill = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL kill_idle_blocks_accept: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat;
    logic rdy;
    // Leave a non-zero result behind first so the reset clear is visible.
    run_op(3'd5, 32'd100, 32'd7, res, lat, rdy);
    tests++; if (res !== 32'd14) begin fails++; $display("FAIL rstmid_setup_result: got %h expected 0000000e", res); end
    @(negedge clk);
    in_valid = 1'b1; funct3 = 3'd0; op_a = $urandom; op_b = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL rstmid_result: got %h expected 00000000", result); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, res, lat, rdy);
    tests++; if (res !== 32'h1) begin fails++; $display("FAIL rstmid_next_result: got %h expected 00000001", res); end
    tests++; if (lat !== XLEN) begin fails++; $display("FAIL rstmid_next_latency: got %0d expected %0d", lat, XLEN); end
  endtask

  // Accepts a new request on the first cycle in_ready returns, repeatedly.
  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [2:0] f;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      f = 3'($urandom); a = pick(); b = pick();
      in_valid = 1'b1; funct3 = f; op_a = a; op_b = b;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
      tests++; if (result !== ref_op(f, a, b)) begin fails++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, result, ref_op(f, a, b)); end
      tests++; if (cyc !== ref_lat(f, a, b)) begin fails++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, cyc, ref_lat(f, a, b)); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    funct3 = 3'd0; op_a = '0; op_b = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_kill();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
